// File: rtl/procyon_lsu_sq_ctrl_pkg.sv
// Shared types and helpers for the store-queue controller.
package procyon_lsu_sq_ctrl_pkg;

  localparam int PCYN_OP_WIDTH = 5;

  typedef enum logic {
    SQ_CTRL_STATE_IDLE = 1'b0,
    SQ_CTRL_STATE_WAIT = 1'b1
  } sq_ctrl_state_t;

  // Priority encoder: index of the lowest set bit (0 when none); vectors up to 64 bits.
  function automatic int lowest_set_idx(input logic [63:0] vec);
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!found && vec[i]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/procyon_lsu_sq_ctrl_if.sv
// Bundle between the SQ controller (master) and the SQ entries / LSU side (slave).
interface procyon_lsu_sq_ctrl_if
  import procyon_lsu_sq_ctrl_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 5
);
  logic                             i_flush;
  logic                             i_alloc_valid;
  logic                             o_alloc_ready;
  logic [DEPTH-1:0]                 o_alloc_select;
  logic [DEPTH-1:0]                 i_entry_empty;
  logic [DEPTH-1:0]                 i_entry_retirable;
  logic [DEPTH-1:0]                 i_entry_rob_ack;
  logic [DEPTH*PCYN_OP_WIDTH-1:0]   i_entry_op;
  logic [DEPTH*ROB_W-1:0]           i_entry_tag;
  logic [DEPTH*ADDR_W-1:0]          i_entry_addr;
  logic [DEPTH*DATA_W-1:0]          i_entry_data;
  logic                             i_lsu_stall;
  logic                             o_retire_en;
  logic [DEPTH-1:0]                 o_retire_select;
  logic [PCYN_OP_WIDTH-1:0]         o_retire_op;
  logic [ROB_W-1:0]                 o_retire_tag;
  logic [ADDR_W-1:0]                o_retire_addr;
  logic [DATA_W-1:0]                o_retire_data;
  logic                             i_update_en;
  logic [DEPTH-1:0]                 o_update_select;
  logic                             o_inflight;
  logic                             o_rob_retire_ack;

  modport master (
    input  i_flush, i_alloc_valid, i_entry_empty, i_entry_retirable, i_entry_rob_ack,
           i_entry_op, i_entry_tag, i_entry_addr, i_entry_data, i_lsu_stall, i_update_en,
    output o_alloc_ready, o_alloc_select, o_retire_en, o_retire_select, o_retire_op,
           o_retire_tag, o_retire_addr, o_retire_data, o_update_select, o_inflight,
           o_rob_retire_ack
  );

  modport slave (
    output i_flush, i_alloc_valid, i_entry_empty, i_entry_retirable, i_entry_rob_ack,
           i_entry_op, i_entry_tag, i_entry_addr, i_entry_data, i_lsu_stall, i_update_en,
    input  o_alloc_ready, o_alloc_select, o_retire_en, o_retire_select, o_retire_op,
           o_retire_tag, o_retire_addr, o_retire_data, o_update_select, o_inflight,
           o_rob_retire_ack
  );

endinterface

// File: rtl/procyon_lsu_sq_ctrl_rr_picker.sv
// Round-robin picker: grants the first requester at or after ptr_i, wrapping past the top.
module procyon_rr_picker #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [DEPTH-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Walk offsets from farthest to nearest so the closest requester to ptr_i wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    idx_o = '0;
    cand  = '0;
    for (int off = DEPTH - 1; off >= 0; off--) begin
      cand = ptr_i + IDX_W'(off);
      if (req_i[cand]) idx_o = cand;
    end
  end

  assign valid_o = |req_i;
  assign grant_o = valid_o ? (DEPTH'(1) << idx_o) : '0;

endmodule

// File: rtl/procyon_lsu_sq_ctrl.sv
// Store-queue controller: allocates free entries, launches one nonspeculative store
// at a time into the LSU and routes its update back to the owning entry.
module procyon_lsu_sq_ctrl
  import procyon_lsu_sq_ctrl_pkg::*;
#(
  parameter int OPTN_SQ_DEPTH      = 8,
  parameter int OPTN_SQ_IDX_WIDTH  = $clog2(OPTN_SQ_DEPTH),
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5
) (
  input logic                   clk,
  input logic                   rst,
  procyon_lsu_sq_ctrl_if.master sq
);

  localparam int D  = OPTN_SQ_DEPTH;
  localparam int IW = OPTN_SQ_IDX_WIDTH;

  sq_ctrl_state_t state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  launched_idx_q, launched_idx_d;

  logic [D-1:0]   grant_onehot;
  logic [IW-1:0]  grant_idx;
  logic           grant_valid;
  logic [IW-1:0]  alloc_idx;
  logic           alloc_ready;
  logic           retire_en;
  logic [D-1:0]   retire_select;
  logic [D-1:0]   update_select;
  logic           inflight;

  assign alloc_idx   = IW'(lowest_set_idx(64'(sq.i_entry_empty)));
  assign alloc_ready = |sq.i_entry_empty;

  assign sq.o_alloc_ready    = alloc_ready;
  assign sq.o_alloc_select   = (D'(1) << alloc_idx) & {D{alloc_ready & sq.i_alloc_valid & ~sq.i_flush}};
  assign sq.o_rob_retire_ack = |sq.i_entry_rob_ack;

  procyon_rr_picker #(
    .DEPTH (D),
    .IDX_W (IW)
  ) u_rr_picker (
    .req_i   (sq.i_entry_retirable),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_onehot),
    .idx_o   (grant_idx),
    .valid_o (grant_valid)
  );

  // Payload always follows the picker; consumers only look at it when o_retire_en is set.
  assign sq.o_retire_op   = sq.i_entry_op[grant_idx*PCYN_OP_WIDTH +: PCYN_OP_WIDTH];
  assign sq.o_retire_tag  = sq.i_entry_tag[grant_idx*OPTN_ROB_IDX_WIDTH +: OPTN_ROB_IDX_WIDTH];
  assign sq.o_retire_addr = sq.i_entry_addr[grant_idx*OPTN_ADDR_WIDTH +: OPTN_ADDR_WIDTH];
  assign sq.o_retire_data = sq.i_entry_data[grant_idx*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH];

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    launched_idx_d = launched_idx_q;
    retire_en      = 1'b0;
    retire_select  = '0;
    update_select  = '0;
    inflight       = 1'b0;
    case (state_q)
      SQ_CTRL_STATE_IDLE: begin
        retire_en = grant_valid & ~sq.i_lsu_stall & ~sq.i_flush;
        if (retire_en) begin
          retire_select  = grant_onehot;
          launched_idx_d = grant_idx;
          rr_ptr_d       = grant_idx + IW'(1);
          state_d        = SQ_CTRL_STATE_WAIT;
        end
      end
      SQ_CTRL_STATE_WAIT: begin
        inflight      = 1'b1;
        // A flush suppresses routing; the entry itself drops back from LAUNCHED.
        update_select = (D'(1) << launched_idx_q) & {D{sq.i_update_en & ~sq.i_flush}};
        if (sq.i_update_en || sq.i_flush) state_d = SQ_CTRL_STATE_IDLE;
      end
      default: state_d = SQ_CTRL_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SQ_CTRL_STATE_IDLE;
      rr_ptr_q       <= '0;
      launched_idx_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      launched_idx_q <= launched_idx_d;
    end
  end

  assign sq.o_retire_en     = retire_en;
  assign sq.o_retire_select = retire_select;
  assign sq.o_update_select = update_select;
  assign sq.o_inflight      = inflight;

endmodule

// File: tb/tb_procyon_lsu_sq_ctrl.sv
// Directed plus randomized bench for procyon_lsu_sq_ctrl against a queue-level reference model.
module tb_procyon_lsu_sq_ctrl;
  import procyon_lsu_sq_ctrl_pkg::*;

  localparam int D  = 8;
  localparam int IW = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int OW = PCYN_OP_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  procyon_lsu_sq_ctrl_if #(.DEPTH(D), .ADDR_W(AW), .DATA_W(DW), .ROB_W(RW)) sqIf ();

  procyon_lsu_sq_ctrl #(
    .OPTN_SQ_DEPTH      (D),
    .OPTN_SQ_IDX_WIDTH  (IW),
    .OPTN_DATA_WIDTH    (DW),
    .OPTN_ADDR_WIDTH    (AW),
    .OPTN_ROB_IDX_WIDTH (RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sq  (sqIf)
  );

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [AW-1:0] addrArr [D];
  logic [DW-1:0] dataArr [D];
  logic [RW-1:0] tagArr  [D];
  logic [OW-1:0] opArr   [D];

  // Reference model: where the round-robin search starts, and the store in flight.
  int mPtr      = 0;
  int mLaunched = 0;
  bit mInflight = 1'b0;

  function automatic int lowestIdx(input logic [D-1:0] v);
    for (int i = 0; i < D; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rrGrant(input logic [D-1:0] req, input int ptr);
    for (int k = 0; k < D; k++) if (req[(ptr + k) % D]) return (ptr + k) % D;
    return -1;
  endfunction

  task automatic loadPayload();
    for (int i = 0; i < D; i++) begin
      addrArr[i] = $urandom;
      dataArr[i] = $urandom;
      tagArr[i]  = RW'($urandom);
      opArr[i]   = OW'($urandom);
      sqIf.i_entry_addr[i*AW +: AW] = addrArr[i];
      sqIf.i_entry_data[i*DW +: DW] = dataArr[i];
      sqIf.i_entry_tag[i*RW +: RW]  = tagArr[i];
      sqIf.i_entry_op[i*OW +: OW]   = opArr[i];
    end
  endtask

  task automatic applyStimulus(input logic [D-1:0] empty, input logic [D-1:0] ret,
                               input logic [D-1:0] ack, input logic stall, input logic flush,
                               input logic allocV, input logic updEn, input logic rstIn);
    sqIf.i_entry_empty     = empty;
    sqIf.i_entry_retirable = ret;
    sqIf.i_entry_rob_ack   = ack;
    sqIf.i_lsu_stall       = stall;
    sqIf.i_flush           = flush;
    sqIf.i_alloc_valid     = allocV;
    sqIf.i_update_en       = updEn;
    rst                    = rstIn;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    int           a, g;
    logic         expEn;
    logic [D-1:0] expAlloc, expRetSel, expUpd;
    a        = lowestIdx(sqIf.i_entry_empty);
    expAlloc = (a >= 0 && sqIf.i_alloc_valid && !sqIf.i_flush) ? (D'(1) << a) : '0;
    g        = rrGrant(sqIf.i_entry_retirable, mPtr);
    expEn    = !mInflight && g >= 0 && !sqIf.i_lsu_stall && !sqIf.i_flush;
    expRetSel = expEn ? (D'(1) << g) : '0;
    expUpd   = (mInflight && sqIf.i_update_en && !sqIf.i_flush) ? (D'(1) << mLaunched) : '0;
    checkOutput({tag, ".allocReady"}, sqIf.o_alloc_ready, a >= 0);
    checkOutput({tag, ".allocSel"}, sqIf.o_alloc_select, expAlloc);
    checkOutput({tag, ".retireEn"}, sqIf.o_retire_en, expEn);
    checkOutput({tag, ".retireSel"}, sqIf.o_retire_select, expRetSel);
    checkOutput({tag, ".updateSel"}, sqIf.o_update_select, expUpd);
    checkOutput({tag, ".inflight"}, sqIf.o_inflight, mInflight);
    checkOutput({tag, ".robAck"}, sqIf.o_rob_retire_ack, sqIf.i_entry_rob_ack != '0);
    if (expEn) begin
      checkOutput({tag, ".retireAddr"}, sqIf.o_retire_addr, addrArr[g]);
      checkOutput({tag, ".retireData"}, sqIf.o_retire_data, dataArr[g]);
      checkOutput({tag, ".retireTag"}, sqIf.o_retire_tag, tagArr[g]);
      checkOutput({tag, ".retireOp"}, sqIf.o_retire_op, opArr[g]);
    end
  endtask

  task automatic stepClock();
    int   g;
    logic en;
    g  = rrGrant(sqIf.i_entry_retirable, mPtr);
    en = !mInflight && g >= 0 && !sqIf.i_lsu_stall && !sqIf.i_flush;
    @(posedge clk);
    if (rst) begin
      mPtr      = 0;
      mLaunched = 0;
      mInflight = 1'b0;
    end else if (en) begin
      mLaunched = g;
      mPtr      = (g + 1) % D;
      mInflight = 1'b1;
    end else if (mInflight && (sqIf.i_update_en || sqIf.i_flush)) begin
      mInflight = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic runCycle(input string tag, input logic [D-1:0] empty, input logic [D-1:0] ret,
                          input logic [D-1:0] ack, input logic stall, input logic flush,
                          input logic allocV, input logic updEn, input logic rstIn);
    applyStimulus(empty, ret, ack, stall, flush, allocV, updEn, rstIn);
    checkModel(tag);
    stepClock();
  endtask

  initial begin
    loadPayload();
    applyStimulus(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stepClock();
    stepClock();

    applyStimulus(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkModel("reset");
    checkOutput("reset.inflightZero", sqIf.o_inflight, 1'b0);
    checkOutput("reset.updateZero", sqIf.o_update_select, 8'h00);
    stepClock();

    applyStimulus(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkModel("allocFF");
    checkOutput("allocFF.sel", sqIf.o_alloc_select, 8'h01);
    stepClock();
    applyStimulus(8'hFE, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkModel("allocFE");
    checkOutput("allocFE.sel", sqIf.o_alloc_select, 8'h02);
    stepClock();
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkModel("allocFull");
    checkOutput("allocFull.sel", sqIf.o_alloc_select, 8'h00);
    checkOutput("allocFull.ready", sqIf.o_alloc_ready, 1'b0);
    stepClock();

    applyStimulus(8'h0F, 8'h81, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkModel("rrFirst");
    checkOutput("rrFirst.sel", sqIf.o_retire_select, 8'h01);
    stepClock();
    runCycle("rrUpd0", 8'h0F, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h0F, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkModel("rrWrap");
    checkOutput("rrWrap.sel", sqIf.o_retire_select, 8'h80);
    stepClock();
    runCycle("rrUpd7", 8'h0F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    runCycle("launch5", 8'h00, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkModel("wait5Idle");
    checkOutput("wait5Idle.upd", sqIf.o_update_select, 8'h00);
    stepClock();
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkModel("wait5Upd");
    checkOutput("wait5Upd.upd", sqIf.o_update_select, 8'h20);
    stepClock();
    runCycle("after5", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h00, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkModel("stall");
      checkOutput("stall.en", sqIf.o_retire_en, 1'b0);
      stepClock();
    end
    applyStimulus(8'h00, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkModel("unstall");
    checkOutput("unstall.addr", sqIf.o_retire_addr, addrArr[2]);
    checkOutput("unstall.sel", sqIf.o_retire_select, 8'h04);
    stepClock();

    applyStimulus(8'h00, 8'h04, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkModel("flushWait");
    checkOutput("flushWait.upd", sqIf.o_update_select, 8'h00);
    stepClock();
    applyStimulus(8'hFF, 8'h04, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkModel("flushIdle");
    checkOutput("flushIdle.inflight", sqIf.o_inflight, 1'b0);
    checkOutput("flushIdle.en", sqIf.o_retire_en, 1'b0);
    checkOutput("flushIdle.alloc", sqIf.o_alloc_select, 8'h00);
    stepClock();

    applyStimulus(8'h00, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkModel("robAck");
    checkOutput("robAck.ack", sqIf.o_rob_retire_ack, 1'b1);
    stepClock();

    runCycle("launch6", 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkModel("rstInWait");
    stepClock();
    applyStimulus(8'h00, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkModel("afterRst");
    checkOutput("afterRst.inflight", sqIf.o_inflight, 1'b0);
    checkOutput("afterRst.sel", sqIf.o_retire_select, 8'h01);
    stepClock();
    runCycle("afterRstUpd", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) loadPayload();
      runCycle("rand", D'($urandom), D'($urandom & $urandom), D'($urandom & $urandom & $urandom),
               ($urandom % 4) == 0, ($urandom % 16) == 0, 1'($urandom), ($urandom % 3) == 0,
               ($urandom % 100) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
